// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v position counters, sync/blank decode
// and a slow animation strobe, all registered on the same edge.
module vga_timing_gen #(
  parameter int CLK_DIV     = 2,
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SLOW_FRAMES = 30
) (
  input  logic       clock,
  input  logic       reset,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pixelEn,
  output logic       slowPulse
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRM_W   = (SLOW_FRAMES > 1) ? $clog2(SLOW_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(SLOW_FRAMES - 1);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VISL = 10'(H_VIS);
  localparam logic [9:0] V_VISL = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             bright_q, bright_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             pix_q, pix_d;
  logic             slow_q, slow_d;
  logic             tick;
  logic             wrap;

  always_comb begin
    tick   = (div_q == DIV_MAX);
    div_d  = tick ? '0 : div_q + DIV_W'(1);
    h_d    = h_q;
    v_d    = v_q;
    frm_d  = frm_q;
    wrap   = 1'b0;
    slow_d = 1'b0;
    if (tick) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        if (v_q == V_MAX) begin
          v_d  = '0;
          wrap = 1'b1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    if (wrap) begin
      if (frm_q == FRM_MAX) begin
        frm_d  = '0;
        slow_d = 1'b1;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end
    // decode the position that will be shown after this edge
    bright_d = (h_d < H_VISL) && (v_d < V_VISL);
    hsync_d  = !((h_d >= HS_BEG) && (h_d <= HS_END));
    vsync_d  = !((v_d >= VS_BEG) && (v_d <= VS_END));
    pix_d    = tick;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q    <= '0;
      frm_q    <= '0;
      h_q      <= H_MAX;
      v_q      <= V_MAX;
      bright_q <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      pix_q    <= 1'b0;
      slow_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      frm_q    <= frm_d;
      h_q      <= h_d;
      v_q      <= v_d;
      bright_q <= bright_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      pix_q    <= pix_d;
      slow_q   <= slow_d;
    end
  end

  assign hCount    = h_q;
  assign vCount    = v_q;
  assign bright    = bright_q;
  assign hSync     = hsync_q;
  assign vSync     = vsync_q;
  assign pixelEn   = pix_q;
  assign slowPulse = slow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets checked every clock against
// an arithmetic model of position versus clocks since reset release.
module tb_vga_timing_gen;

  typedef struct {
    int cd, hv, hf, hs, hb, vv, vf, vs, vb, sf;
  } cfg_t;

  typedef struct {
    int h, v, br, hs, vs, pe, sp;
  } exp_t;

  localparam cfg_t CA = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 30};
  localparam cfg_t CB = '{1, 8, 1, 2, 1, 4, 1, 1, 1, 1};
  localparam cfg_t CC = '{3, 10, 2, 3, 2, 5, 1, 2, 1, 2};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_a, rst_b, rst_c;
  logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
  logic br_a, hs_a, vs_a, pe_a, sp_a;
  logic br_b, hs_b, vs_b, pe_b, sp_b;
  logic br_c, hs_c, vs_c, pe_c, sp_c;

  int na = 0, nb = 0, nc = 0;
  int checks = 0, failures = 0;

  vga_timing_gen u_a (
    .clock(clock), .reset(rst_a), .hCount(h_a), .vCount(v_a),
    .bright(br_a), .hSync(hs_a), .vSync(vs_a),
    .pixelEn(pe_a), .slowPulse(sp_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VIS(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SLOW_FRAMES(1)
  ) u_b (
    .clock(clock), .reset(rst_b), .hCount(h_b), .vCount(v_b),
    .bright(br_b), .hSync(hs_b), .vSync(vs_b),
    .pixelEn(pe_b), .slowPulse(sp_b)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_VIS(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(5), .V_FP(1), .V_SYNC(2), .V_BP(1), .SLOW_FRAMES(2)
  ) u_c (
    .clock(clock), .reset(rst_c), .hCount(h_c), .vCount(v_c),
    .bright(br_c), .hSync(hs_c), .vSync(vs_c),
    .pixelEn(pe_c), .slowPulse(sp_c)
  );

  // clocks elapsed since each DUT last saw reset low
  always @(posedge clock) begin
    na <= rst_a ? na + 1 : 0;
    nb <= rst_b ? nb + 1 : 0;
    nc <= rst_c ? nc + 1 : 0;
  end

  function automatic exp_t model(input cfg_t c, input int n);
    exp_t e;
    int ht, vt, fr, a, p, hsb, vsb;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    fr = ht * vt;
    a  = n / c.cd;
    e  = '{ht - 1, vt - 1, 0, 1, 1, 0, 0};
    if (a == 0) return e;
    p    = (a - 1) % fr;
    e.h  = p % ht;
    e.v  = p / ht;
    hsb  = c.hv + c.hf;
    vsb  = c.vv + c.vf;
    e.br = (e.h < c.hv && e.v < c.vv) ? 1 : 0;
    e.hs = (e.h >= hsb && e.h < hsb + c.hs) ? 0 : 1;
    e.vs = (e.v >= vsb && e.v < vsb + c.vs) ? 0 : 1;
    e.pe = (n % c.cd == 0) ? 1 : 0;
    e.sp = (e.pe == 1 && p == 0 &&
            (((a - 1) / fr + 1) % c.sf) == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_dut(input string nm, input cfg_t c, input int n,
                         input logic [9:0] h, input logic [9:0] v,
                         input logic br, input logic hs, input logic vs,
                         input logic pe, input logic sp);
    exp_t e;
    e = model(c, n);
    chk($sformatf("%s.hCount@%0d", nm, n), 32'(h), e.h);
    chk($sformatf("%s.vCount@%0d", nm, n), 32'(v), e.v);
    chk($sformatf("%s.bright@%0d", nm, n), 32'(br), e.br);
    chk($sformatf("%s.hSync@%0d", nm, n), 32'(hs), e.hs);
    chk($sformatf("%s.vSync@%0d", nm, n), 32'(vs), e.vs);
    chk($sformatf("%s.pixelEn@%0d", nm, n), 32'(pe), e.pe);
    chk($sformatf("%s.slowPulse@%0d", nm, n), 32'(sp), e.sp);
  endtask

  task automatic chk_all();
    chk_dut("A", CA, na, h_a, v_a, br_a, hs_a, vs_a, pe_a, sp_a);
    chk_dut("B", CB, nb, h_b, v_b, br_b, hs_b, vs_b, pe_b, sp_b);
    chk_dut("C", CC, nc, h_c, v_c, br_c, hs_c, vs_c, pe_c, sp_c);
  endtask

  int ha = 0, hb = 0, hc = 0;

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    repeat (5) begin
      @(negedge clock);
      chk_all();
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(negedge clock);
      chk_all();
      if (failures > 60) break;
      if (ha > 0) ha--;
      if (ha == 0 && cyc > 6000 && $urandom_range(7999) == 0)
        ha = $urandom_range(1, 3);
      if (hb > 0) hb--;
      if (hb == 0 && $urandom_range(1499) == 0)
        hb = $urandom_range(1, 3);
      if (hc > 0) hc--;
      if (hc == 0 && $urandom_range(2999) == 0)
        hc = $urandom_range(1, 3);
      rst_a = (ha == 0);
      rst_b = (hb == 0);
      rst_c = (hc == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
